// File: rtl/rev_alu_seq_if.sv
// Request/response bundle for the bit-serial reversible ALU sequencer.
interface rev_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             busy;

  // Requester / result consumer side
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, ovf, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, ovf, busy
  );
endinterface

// File: rtl/rev_alu_seq.sv
// Bit-serial sequencer around a 1-bit reversible ALU slice. One WIDTH-bit op
// is accepted, stepped LSB-first one bit per clock, then presented with flags.

// One bit of the reversible ALU: DPG-style full adder (propagate = a^b',
// generate = a&b'), Toffoli-style AND terms, Fredkin-style operand select.
module rev_alu_slice (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       r,
  output logic       cout
);
  logic bp, p;

  // Combinational slice: arithmetic path plus the six logic functions
  always_comb begin
    bp   = b ^ (op == 3'b001);          // SUB inverts B
    p    = a ^ bp;                      // propagate
    cout = (a & bp) | (p & cin);        // majority(a, b', cin)
    r    = 1'b0;
    unique case (op)
      3'b000, 3'b001: r = p ^ cin;
      3'b010:         r = a & b;
      3'b011:         r = a | b;
      3'b100:         r = a ^ b;
      3'b101:         r = ~(a & b);
      3'b110:         r = ~a;
      3'b111:         r = b;
      default:        r = 1'b0;
    endcase
  end
endmodule

module rev_alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  rev_alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;

  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, ovf_q;

  logic             s_r, s_cout;
  logic [WIDTH-1:0] r_next;
  logic             arith;

  rev_alu_slice u_slice (
    .op  (op_r),
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (c_reg),
    .r   (s_r),
    .cout(s_cout)
  );

  // Result shifts in at the MSB so after WIDTH steps bit 0 lands at bit 0
  always_comb begin
    r_next = {s_r, r_sh[WIDTH-1:1]};
    arith  = (op_r == 3'b000) || (op_r == 3'b001);
  end

  // Control FSM, datapath shifters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      r_sh        <= '0;
      c_reg       <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_r       <= bus.op;
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            r_sh       <= '0;
            c_reg      <= (bus.op == 3'b001);   // SUB: +~B+1
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          c_reg <= s_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // c_reg here is the carry into the MSB; s_cout is the carry out
            result_q    <= r_next;
            carry_q     <= arith & s_cout;
            ovf_q       <= arith & (c_reg ^ s_cout);
            zero_q      <= ~|r_next;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rev_alu_seq.sv
// Self-checking bench for rev_alu_seq (WIDTH=16).
module tb_rev_alu_seq;
  localparam int W = 16;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  logic clk, rst;
  int   n_cmp, n_fail;

  rev_alu_seq_if #(.WIDTH(W)) bus ();

  rev_alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    e.c = 1'b0;
    e.o = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c = s[W];
        e.o = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = s[W-1:0];
        e.c = s[W];
        e.o = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~(a & b);
      3'd6: e.res = ~a;
      default: e.res = b;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".busy"},      32'(bus.busy),      32'd0);
    chk({tag, ".result"},    32'(bus.result),    32'd0);
    chk({tag, ".carry"},     32'(bus.carry),     32'd0);
    chk({tag, ".zero"},      32'(bus.zero),      32'd0);
    chk({tag, ".ovf"},       32'(bus.ovf),       32'd0);
  endtask

  // Issue one op and collect it; caller sits at #1 after a rising edge
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t got, output int lat);
    int bound;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    bound = 0;
    while (!bus.in_ready && bound < 100) begin @(posedge clk); #1; bound++; end
    if (bound >= 100) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    got.res = bus.result; got.c = bus.carry; got.z = bus.zero; got.o = bus.ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  exp_t got, e;
  exp_t expq[$];
  int   lat;

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0;

    vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd2, 16'hA5A5, 16'h0F0F, 16'h0505, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 16'hA5A5, 16'h0F0F, 16'hAFAF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd4, 16'hA5A5, 16'h0F0F, 16'hAAAA, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 16'hA5A5, 16'h0F0F, 16'hFAFA, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 16'hA5A5, 16'h0F0F, 16'h5A5A, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 16'hA5A5, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd2, 16'h00FF, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b0});

    #12;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, got, lat);
      chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(W));
      chk($sformatf("vec%0d.result", i), 32'(got.res), 32'(vecs[i].res));
      chk($sformatf("vec%0d.carry", i),  32'(got.c),   32'(vecs[i].c));
      chk($sformatf("vec%0d.zero", i),   32'(got.z),   32'(vecs[i].z));
      chk($sformatf("vec%0d.ovf", i),    32'(got.o),   32'(vecs[i].o));
    end

    // Backpressure: hold DONE for 5 cycles while inputs wiggle
    bus.op = 3'd0; bus.a = 16'h0003; bus.b = 16'h0004; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp.busy_in_run", 32'(bus.busy), 32'd1);
    for (int i = 0; i < W; i++) begin @(posedge clk); #1; end
    chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op = 3'($urandom);
      bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp.hold_result", 32'(bus.result), 32'h7);
      chk("bp.hold_flags", {29'd0, bus.carry, bus.zero, bus.ovf}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp.release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp.release_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(3'd4, 16'h1111, 16'h0101, got, lat);
    chk("bp.next_result", 32'(got.res), 32'h1010);
    chk("bp.next_latency", 32'(lat), 32'(W));

    // Asynchronous reset during RUN, after bits 0..6 have been processed
    bus.op = 3'd0; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    chk("rst.busy_before", 32'(bus.busy), 32'd1);
    chk("rst.result_before", 32'(bus.result), 32'h1010);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    #5 rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("rst_after");
    do_op(3'd0, 16'h1234, 16'h1111, got, lat);
    chk("rst.fresh_result", 32'(got.res), 32'h2345);
    chk("rst.fresh_flags", {29'd0, got.c, got.z, got.o}, 32'd0);
    chk("rst.fresh_latency", 32'(lat), 32'(W));

    // Back-to-back random traffic against the model
    begin
      int done_cnt, cyc, last_acc, budget;
      logic acc, dn;
      done_cnt = 0; cyc = 0; last_acc = -1; budget = 1000 * (W + 2) + 200;
      bus.op = 3'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      while (done_cnt < 1000 && cyc < budget) begin
        acc = bus.in_valid && bus.in_ready;
        dn  = bus.out_valid && bus.out_ready;
        if (dn) begin
          if (expq.size() == 0) chk("b2b.unexpected_result", 32'd1, 32'd0);
          else begin
            e = expq.pop_front();
            chk("b2b.result", 32'(bus.result), 32'(e.res));
            chk("b2b.flags", {29'd0, bus.carry, bus.zero, bus.ovf}, {29'd0, e.c, e.z, e.o});
          end
          done_cnt++;
        end
        if (acc) begin
          expq.push_back(model(bus.op, bus.a, bus.b));
          if (last_acc >= 0) chk("b2b.spacing", 32'(cyc - last_acc), 32'(W + 2));
          last_acc = cyc;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          bus.op = 3'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
          if (($urandom & 7) == 0) bus.a = bus.b;
        end
      end
      if (done_cnt < 1000) chk("b2b.timeout", 32'(done_cnt), 32'd1000);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
